lpfilter_mc: RTL and testbench

LPFILTER_MC -- requirements
Module: lpfilter_mc

---
 rtl/lpfilter_mc_pkg.sv | 25 ++
 rtl/lpf_delay_ram.sv | 26 ++
 rtl/lpfilter_mc.sv | 179 +++++++++++++++++
 tb/tb_lpfilter_mc.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lpfilter_mc_pkg.sv
// Shared types and helpers for the lpfilter_mc moving-average filter.
package lpfilter_mc_pkg;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        FLUSH = 2'd2,
        ACK   = 2'd3
    } state_e;

    localparam int CHTAG_W = 4;

    function automatic int clog2(input int value);
        int res;
        int v;
        res = 0;
        v   = value - 1;
        while (v > 0) begin
            res++;
            v = v >> 1;
        end
        return res;
    endfunction

endpackage

// File: rtl/lpf_delay_ram.sv
// Per-channel delay-line storage: simple dual-port, registered write, asynchronous read.
module lpf_delay_ram #(
    parameter int C_DWIDTH = 16,
    parameter int C_DEPTH  = 16,
    parameter int C_AWIDTH = 4
) (
    input  logic                clk,
    input  logic                we_i,
    input  logic [C_AWIDTH-1:0] waddr_i,
    input  logic [C_DWIDTH-1:0] wdata_i,
    input  logic [C_AWIDTH-1:0] raddr_i,
    output logic [C_DWIDTH-1:0] rdata_o
);

    logic [C_DWIDTH-1:0] mem_q [C_DEPTH];

    // NOTE: the array has no reset so it maps onto RAM; the controller zeroes it with a FLUSH sweep.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/lpfilter_mc.sv
// Round-robin multi-channel moving-average filter with a reconfiguration (flush) handshake.
// Define LPFILTER_MC_CHTAG_EN to carry the channel index in p_data[31:28].
module lpfilter_mc
    import lpfilter_mc_pkg::*;
#(
    parameter int C_DWIDTH   = 16,
    parameter int C_TAPS     = 8,
    parameter int C_CHANNELS = 2
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        c_prdy,
    output logic        c_crdy,
    output logic        c_cerr,
    input  logic [31:0] c_data,
    output logic        p_prdy,
    input  logic        p_crdy,
    input  logic        p_cerr,
    output logic [31:0] p_data,
    input  logic        rc_reqn,
    output logic        rc_ackn
);

    localparam int TW    = clog2(C_TAPS);
    localparam int CW    = (C_CHANNELS > 1) ? clog2(C_CHANNELS) : 1;
    localparam int SW    = C_DWIDTH + TW;
    localparam int DEPTH = C_CHANNELS * C_TAPS;
    localparam int AW    = clog2(DEPTH);
    localparam logic [CW-1:0] CH_LAST    = CW'(C_CHANNELS - 1);
    localparam logic [AW-1:0] FLUSH_LAST = AW'(DEPTH - 1);

    state_e                 state_q, state_d;
    logic                   init_q, init_d;
    logic [CW-1:0]          ch_q, ch_d;
    logic                   p_prdy_q, p_prdy_d;
    logic [31:0]            p_data_q, p_data_d;
    logic [AW-1:0]          flush_cnt_q, flush_cnt_d;
    logic [TW-1:0]          ptr_q [C_CHANNELS];
    logic signed [SW-1:0]   sum_q [C_CHANNELS];

    logic                   accept, take, flush_done, in_flush;
    logic [TW-1:0]          ptr_cur;
    logic [AW-1:0]          rd_addr;
    logic signed [C_DWIDTH-1:0] sample, oldest, avg;
    logic signed [SW-1:0]   sum_new;
    logic [31:0]            avg_ext, p_word;
    logic                   ram_we;
    logic [AW-1:0]          ram_waddr;
    logic [C_DWIDTH-1:0]    ram_wdata;
    logic                   unused_ok;

    assign unused_ok = ^{p_cerr, c_data[31:C_DWIDTH]};

    // init_q marks the flush forced by reset: it runs silently and returns to RUN, not ACK.
    assign c_crdy  = (state_q == RUN) && !init_q && (!p_prdy_q || p_crdy);
    assign c_cerr  = (state_q != RUN) && !init_q;
    assign rc_ackn = (state_q != ACK);
    assign p_prdy  = p_prdy_q;
    assign p_data  = p_data_q;

    assign accept     = c_prdy && c_crdy;
    assign take       = p_prdy_q && p_crdy;
    assign in_flush   = (state_q == FLUSH);
    assign flush_done = in_flush && (flush_cnt_q == FLUSH_LAST);

    assign ptr_cur = ptr_q[ch_q];
    assign rd_addr = AW'({ch_q, ptr_cur});
    assign sample  = c_data[C_DWIDTH-1:0];
    assign sum_new = sum_q[ch_q] + SW'(sample) - SW'(oldest);
    assign avg     = C_DWIDTH'(sum_new >>> TW);
    assign avg_ext = 32'(avg);

`ifdef LPFILTER_MC_CHTAG_EN
    assign p_word = {CHTAG_W'(ch_q), avg_ext[31-CHTAG_W:0]};
`else
    assign p_word = avg_ext;
`endif

    assign ram_we    = rstn && (in_flush || accept);
    assign ram_waddr = in_flush ? flush_cnt_q : rd_addr;
    assign ram_wdata = in_flush ? '0 : sample;

    lpf_delay_ram #(
        .C_DWIDTH (C_DWIDTH),
        .C_DEPTH  (DEPTH),
        .C_AWIDTH (AW)
    ) u_delay_ram (
        .clk     (clk),
        .we_i    (ram_we),
        .waddr_i (ram_waddr),
        .wdata_i (ram_wdata),
        .raddr_i (rd_addr),
        .rdata_o (oldest)
    );

    // NOTE: every next-state variable gets a default first so no path leaves a latch behind.
    always_comb begin
        state_d     = state_q;
        init_d      = init_q;
        ch_d        = ch_q;
        p_prdy_d    = p_prdy_q;
        p_data_d    = p_data_q;
        flush_cnt_d = flush_cnt_q;

        if (take) begin
            p_prdy_d = 1'b0;
        end
        if (accept) begin
            p_prdy_d = 1'b1;
            p_data_d = p_word;
            ch_d     = (ch_q == CH_LAST) ? '0 : ch_q + CW'(1);
        end

        case (state_q)
            RUN: begin
                if (init_q) begin
                    state_d     = FLUSH;
                    flush_cnt_d = '0;
                end else if (!rc_reqn) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (!p_prdy_q) begin
                    state_d     = FLUSH;
                    flush_cnt_d = '0;
                end
            end
            FLUSH: begin
                if (flush_done) begin
                    state_d = init_q ? RUN : ACK;
                    init_d  = 1'b0;
                    ch_d    = '0;
                end else begin
                    flush_cnt_d = flush_cnt_q + AW'(1);
                end
            end
            ACK: begin
                if (rc_reqn) begin
                    state_d = RUN;
                end
            end
            default: state_d = RUN;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers see pre-edge values.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q     <= RUN;
            init_q      <= 1'b1;
            ch_q        <= '0;
            p_prdy_q    <= 1'b0;
            p_data_q    <= '0;
            flush_cnt_q <= '0;
            for (int i = 0; i < C_CHANNELS; i++) begin
                sum_q[i] <= '0;
                ptr_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            init_q      <= init_d;
            ch_q        <= ch_d;
            p_prdy_q    <= p_prdy_d;
            p_data_q    <= p_data_d;
            flush_cnt_q <= flush_cnt_d;
            if (flush_done) begin
                for (int i = 0; i < C_CHANNELS; i++) begin
                    sum_q[i] <= '0;
                    ptr_q[i] <= '0;
                end
            end else if (accept) begin
                sum_q[ch_q] <= sum_new;
                ptr_q[ch_q] <= ptr_cur + TW'(1);
            end
        end
    end

endmodule

// File: tb/tb_lpfilter_mc.sv
// Self-checking bench for lpfilter_mc: windowed-average reference model, random traffic, reconfig and reset.
module tb_lpfilter_mc;

    localparam int DW    = 16;
    localparam int TAPS  = 4;
    localparam int TW    = 2;
    localparam int NCH   = 2;
    localparam int DEPTH = NCH * TAPS;

    localparam int M_NONE   = 0;
    localparam int M_RUN    = 1;
    localparam int M_CANCEL = 2;

`ifdef LPFILTER_MC_CHTAG_EN
    localparam bit TAG_EN = 1'b1;
`else
    localparam bit TAG_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        c_prdy = 1'b0;
    logic        c_crdy;
    logic        c_cerr;
    logic [31:0] c_data = '0;
    logic        p_prdy;
    logic        p_crdy = 1'b0;
    logic        p_cerr = 1'b0;
    logic [31:0] p_data;
    logic        rc_reqn = 1'b1;
    logic        rc_ackn;

    int errors = 0;
    int checks = 0;

    int          hist [NCH][TAPS];
    int          m_ch;
    logic [31:0] exp_q [$];

    always #5 clk = ~clk;

    lpfilter_mc #(
        .C_DWIDTH   (DW),
        .C_TAPS     (TAPS),
        .C_CHANNELS (NCH)
    ) u_dut (
        .clk     (clk),
        .rstn    (rstn),
        .c_prdy  (c_prdy),
        .c_crdy  (c_crdy),
        .c_cerr  (c_cerr),
        .c_data  (c_data),
        .p_prdy  (p_prdy),
        .p_crdy  (p_crdy),
        .p_cerr  (p_cerr),
        .p_data  (p_data),
        .rc_reqn (rc_reqn),
        .rc_ackn (rc_ackn)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] fmt(input int ch, input int avg);
        logic [31:0] v;
        v = avg;
        if (TAG_EN) v[31:28] = 4'(ch);
        return v;
    endfunction

    task automatic model_reset();
        for (int c = 0; c < NCH; c++)
            for (int k = 0; k < TAPS; k++)
                hist[c][k] = 0;
        m_ch = 0;
    endtask

    // Window average: keep the last TAPS samples, sum them, floor-divide by TAPS.
    task automatic model_accept(input logic [31:0] din);
        logic signed [DW-1:0] smp;
        int s;
        smp = din[DW-1:0];
        for (int k = 0; k < TAPS - 1; k++) hist[m_ch][k] = hist[m_ch][k+1];
        hist[m_ch][TAPS-1] = int'(smp);
        s = 0;
        for (int k = 0; k < TAPS; k++) s += hist[m_ch][k];
        exp_q.push_back(fmt(m_ch, s >>> TW));
        m_ch = (m_ch + 1) % NCH;
    endtask

    // One clock: inputs already applied at the falling edge; check, update model, advance.
    task automatic tick(input int mode);
        logic acc, take;
        #1;
        check("p_prdy", p_prdy, exp_q.size() != 0);
        if (p_prdy && exp_q.size() != 0) check("p_data", p_data, exp_q[0]);
        if (mode == M_RUN) begin
            check("run_c_crdy", c_crdy, (exp_q.size() == 0) || p_crdy);
            check("run_c_cerr", c_cerr, 0);
            check("run_rc_ackn", rc_ackn, 1);
        end else if (mode == M_CANCEL) begin
            check("cancel_c_crdy", c_crdy, 0);
            check("cancel_c_cerr", c_cerr, 1);
        end
        acc  = c_prdy & c_crdy;
        take = p_prdy & p_crdy;
        if (take && exp_q.size() != 0) void'(exp_q.pop_front());
        if (acc) model_accept(c_data);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        int n;
        rstn    = 1'b0;
        c_prdy  = 1'b0;
        p_crdy  = 1'b0;
        rc_reqn = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("rst_p_prdy", p_prdy, 0);
        check("rst_p_data", p_data, 0);
        check("rst_c_crdy", c_crdy, 0);
        check("rst_c_cerr", c_cerr, 0);
        check("rst_rc_ackn", rc_ackn, 1);
        @(posedge clk);
        @(negedge clk);
        exp_q.delete();
        model_reset();
        p_crdy = 1'b1;
        rstn   = 1'b1;
        #1;
        n = 0;
        while (!c_crdy && n < DEPTH + 8) begin
            check("init_c_cerr", c_cerr, 0);
            check("init_rc_ackn", rc_ackn, 1);
            check("init_p_prdy", p_prdy, 0);
            @(posedge clk);
            @(negedge clk);
            #1;
            n++;
        end
        check("init_reach_run", c_crdy, 1);
        @(negedge clk);
    endtask

    task automatic feed_const(input logic [31:0] din, input int ch, input int avg);
        c_prdy = 1'b1;
        p_crdy = 1'b1;
        c_data = din;
        tick(M_RUN);
        c_prdy = 1'b0;
        check("const_p_prdy", p_prdy, 1);
        check("const_p_data", p_data, fmt(ch, avg));
    endtask

    task automatic drain();
        c_prdy = 1'b0;
        p_crdy = 1'b1;
        tick(M_RUN);
        tick(M_RUN);
    endtask

    task automatic random_run(input int n);
        for (int i = 0; i < n; i++) begin
            c_prdy = ($urandom_range(3) != 0);
            p_crdy = ($urandom_range(2) != 0);
            c_data = $urandom;
            case ($urandom_range(3))
                0: c_data[15:0] = 16'h7FFF;
                1: c_data[15:0] = 16'h8000;
                default: ;
            endcase
            tick(M_RUN);
        end
    endtask

    task automatic wait_ack(input bit release_mid, output int n);
        n = 0;
        while (rc_ackn && n < DEPTH + 10) begin
            if (release_mid && n == 3) rc_reqn = 1'b1;
            tick(M_CANCEL);
            n++;
        end
    endtask

    initial begin
        int n;
        model_reset();
        @(negedge clk);
        do_reset();

        // Known window values on freshly zeroed history.
        feed_const(32'd100, 0, 25);
        feed_const(32'hFFFF_FF9C, 1, -25);
        feed_const(32'd100, 0, 50);
        feed_const(32'hFFFF_FF9C, 1, -50);
        drain();

        random_run(300);

        // Backpressure: one output held for five cycles, no input lost.
        c_prdy = 1'b1;
        p_crdy = 1'b1;
        c_data = $urandom;
        tick(M_RUN);
        p_crdy = 1'b0;
        for (int i = 0; i < 5; i++) begin
            c_data = $urandom;
            tick(M_RUN);
        end
        p_crdy = 1'b1;
        for (int i = 0; i < 3; i++) begin
            c_data = $urandom;
            tick(M_RUN);
        end
        drain();

        // Reconfiguration with an output pending, request held through ACK.
        c_prdy  = 1'b1;
        p_crdy  = 1'b0;
        c_data  = 32'h0000_1234;
        rc_reqn = 1'b0;
        tick(M_RUN);
        for (int i = 0; i < 3; i++) begin
            tick(M_CANCEL);
            check("drain_rc_ackn", rc_ackn, 1);
        end
        p_crdy = 1'b1;
        tick(M_CANCEL);
        wait_ack(1'b0, n);
        check("drain_flush_len", n, DEPTH + 1);
        #1;
        check("ack_rc_ackn", rc_ackn, 0);
        check("ack_c_cerr", c_cerr, 1);
        check("ack_c_crdy", c_crdy, 0);
        model_reset();
        tick(M_NONE);
        check("ack_hold_rc_ackn", rc_ackn, 0);
        rc_reqn = 1'b1;
        c_prdy  = 1'b0;
        tick(M_NONE);
        check("exit_rc_ackn", rc_ackn, 1);
        check("exit_c_cerr", c_cerr, 0);
        feed_const(32'd8, 0, 2);
        drain();

        // Request released during FLUSH: sequence completes, ACK lasts one cycle.
        rc_reqn = 1'b0;
        tick(M_RUN);
        wait_ack(1'b1, n);
        check("flush_len_released", n, DEPTH + 1);
        check("ack_once_rc_ackn", rc_ackn, 0);
        model_reset();
        tick(M_NONE);
        check("ack_exit_rc_ackn", rc_ackn, 1);
        feed_const(32'd8, 0, 2);
        feed_const(32'hFFFF_FFFF, 1, -1);
        drain();
        random_run(150);
        drain();

        // Reset asserted in the middle of FLUSH.
        rc_reqn = 1'b0;
        tick(M_RUN);
        for (int i = 0; i < 4; i++) tick(M_CANCEL);
        do_reset();
        feed_const(32'd8, 0, 2);
        drain();
        random_run(200);
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
